// File: rtl/add_identity_seq.sv
// Sequential B = A + I on an M x N fixed-point matrix, one element per clock behind a start/done handshake.
// Optional macro ADD_IDENTITY_SAT_EN: diagonal adds saturate at the max positive value instead of wrapping.
module add_identity_seq #(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int nBits = 32,
  parameter int FRAC  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [M*N*nBits-1:0]   a,
  output logic [M*N*nBits-1:0]   b,
  output logic                   busy,
  output logic                   done
);

  localparam int NE = M * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [nBits-1:0] ONE = nBits'(1) << FRAC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [nBits-1:0]  a_in  [NE];
  logic [nBits-1:0]  a_reg [NE];
  logic [nBits-1:0]  b_reg [NE];
  logic [IW-1:0]     idx;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              diag;
  logic [nBits-1:0]  addend;
  logic [nBits-1:0]  sum;

  // Element k sits MSB-first: element (0,0) is the top nBits of the bus.
  for (genvar k = 0; k < NE; k++) begin : g_pack
    assign a_in[k]                        = a[(NE-k)*nBits-1 -: nBits];
    assign b[(NE-k)*nBits-1 -: nBits]     = b_reg[k];
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == IW'(NE - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // row == col can only hold for row < min(M,N) since row < M and col < N while running.
  assign diag   = (32'(row) == 32'(col));
  assign addend = diag ? ONE : '0;

`ifdef ADD_IDENTITY_SAT_EN
  logic [nBits:0] wide;
  assign wide = {a_reg[idx][nBits-1], a_reg[idx]} + {1'b0, addend};
  // Only positive overflow is possible because the addend is never negative.
  assign sum  = (wide[nBits] != wide[nBits-1]) ? {1'b0, {(nBits-1){1'b1}}} : wide[nBits-1:0];
`else
  assign sum  = a_reg[idx] + addend;
`endif

  // NOTE: the matrix arrays are cleared on reset because b must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      row <= '0;
      col <= '0;
      for (int k = 0; k < NE; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NE; k++) a_reg[k] <= a_in[k];
            idx <= '0;
            row <= '0;
            col <= '0;
          end
        end
        RUN: begin
          b_reg[idx] <= sum;
          idx        <= idx + IW'(1);
          if (col == CW'(N - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_identity_seq.sv
// Self-checking bench for add_identity_seq: a 2x2 and a 2x3 instance against a per-cycle matrix model.
// Honours ADD_IDENTITY_SAT_EN the same way the design does.
module tb_add_identity_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start0, start1;
  logic [127:0] a0, b0;
  logic [191:0] a1, b1;
  logic         busy0, done0, busy1, done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_identity_seq #(.M(2), .N(2), .nBits(32), .FRAC(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .busy(busy0), .done(done0)
  );

  add_identity_seq #(.M(2), .N(3), .nBits(32), .FRAC(15)) dut23 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result: each element plus 1.0 where i == j, wrapping or saturating at 32 bits.
  function automatic logic [191:0] expect_b(input logic [191:0] av, input int m, input int n);
    logic [191:0]       r;
    logic signed [31:0] x;
    longint             e;
    int                 k;
    r = '0;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        k = i * n + j;
        x = av[(m*n-k)*32-1 -: 32];
        e = longint'(x);
        if (i == j) e = e + 64'sd32768;
`ifdef ADD_IDENTITY_SAT_EN
        if (e > 64'sh7FFFFFFF) e = 64'sh7FFFFFFF;
`endif
        r[(m*n-k)*32-1 -: 32] = e[31:0];
      end
    end
    return r;
  endfunction

  // Model: phase counts edges since the accepted start (-1 when idle).
  int           phase [2] = '{-1, -1};
  int           mn    [2] = '{4, 6};
  int           rows  [2] = '{2, 2};
  int           cols  [2] = '{2, 3};
  logic         have  [2] = '{1'b0, 1'b0};
  logic [191:0] exp_b [2];
  logic [191:0] pend  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = -1;
        exp_b[d] = '0;
        have[d]  = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (phase[d] < 0) begin
          if ((d == 0) ? start0 : start1) begin
            phase[d] = 0;
            pend[d]  = expect_b((d == 0) ? 192'(a0) : a1, rows[d], cols[d]);
            have[d]  = 1'b0;
          end
        end else begin
          phase[d] = phase[d] + 1;
          if (phase[d] == mn[d]) begin
            exp_b[d] = pend[d];
            have[d]  = 1'b1;
          end
          if (phase[d] > mn[d]) phase[d] = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy%0d", d), 192'((d == 0) ? busy0 : busy1), 192'(phase[d] >= 0));
      check($sformatf("done%0d", d), 192'((d == 0) ? done0 : done1), 192'(phase[d] == mn[d]));
      if (have[d]) check($sformatf("b%0d", d), (d == 0) ? 192'(b0) : b1, exp_b[d]);
    end
  end

  // Launch one operation from a falling edge, wait (bounded) for done, pin latency and result.
  task automatic run(input int d, input logic [191:0] av, input logic [191:0] expb,
                     input int lat, input string name);
    int cyc;
    if (d == 0) begin a0 = av[127:0]; start0 = 1'b1; end
    else        begin a1 = av;        start1 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 1;
    while (!((d == 0) ? done0 : done1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 192'(cyc), 192'(lat));
    check({name, "_b"}, (d == 0) ? 192'(b0) : b1, expb);
    @(negedge clk);
  endtask

  localparam logic [127:0] A_BASIC = {32'h00008000, 32'h00010000, 32'h00018000, 32'h00020000};
  localparam logic [127:0] B_BASIC = {32'h00010000, 32'h00010000, 32'h00018000, 32'h00028000};
`ifdef ADD_IDENTITY_SAT_EN
  localparam logic [31:0]  OVF0    = 32'h7FFFFFFF;
`else
  localparam logic [31:0]  OVF0    = 32'h80004000;
`endif

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    a0     = '0;
    a1     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_b",    192'(b0),    192'(0));
    check("reset_busy", 192'(busy0), 192'(0));
    check("reset_done", 192'(done0), 192'(0));

    run(0, 192'(A_BASIC), 192'(B_BASIC), 5, "basic");

    run(0, 192'({32'hFFFF8000, 32'h0, 32'h0, 32'hFFFF0000}),
        192'({32'h00000000, 32'h0, 32'h0, 32'hFFFF8000}), 5, "neg_diag");

    run(0, 192'({32'h7FFFC000, 32'h0, 32'h0, 32'h0}),
        192'({OVF0, 32'h0, 32'h0, 32'h00008000}), 5, "overflow");

    // Second start two cycles into the first operation must be ignored.
    a0 = A_BASIC;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    a0 = {4{32'h00100000}};
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        check("busy_start_b", 192'(b0), 192'(B_BASIC));
      end
    end
    check("busy_start_done_count", 192'(ndone), 192'(1));

    // Reset after two RUN edges: outputs clear without waiting for a clock.
    a0 = {4{32'h00100000}};
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_b",    192'(b0),    192'(0));
    check("midrun_reset_busy", 192'(busy0), 192'(0));
    check("midrun_reset_done", 192'(done0), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 192'(A_BASIC), 192'(B_BASIC), 5, "after_reset");

    run(1, {6{32'h00008000}},
        {32'h00010000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h00010000, 32'h00008000},
        7, "nonsquare");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
